// File: rtl/video_timing_if.sv
// Raster timing bundle between video_timing (master) and its consumers
// (video_controller and the output encoder).
interface video_timing_if;
  logic        run;
  logic [11:0] pixel;
  logic [11:0] line;
  logic        line_end;
  logic        frame_end;
  logic        halt;
  logic        hsync;
  logic        vsync;
  logic        de;

  modport master (
    input  run,
    output pixel, line, line_end, frame_end, halt, hsync, vsync, de
  );

  modport slave (
    output run,
    input  pixel, line, line_end, frame_end, halt, hsync, vsync, de
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters, line/frame strobes, halt,
// and hsync/vsync/de delayed to line up with the downstream pixel pipeline.
module video_timing #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int SYNC_DELAY = 2
) (
  input logic         clk,
  input logic         rst,
  video_timing_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {STOPPED, RUNNING} state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  state_t      state_q, state_d;
  logic [11:0] pixel_q, pixel_d;
  logic [11:0] line_q, line_d;
  logic        line_end_q, line_end_d;
  logic        frame_end_q, frame_end_d;
  logic        halt_q, halt_d;
  sync_t       sync_raw;
  sync_t       sync_out;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STOPPED;
      pixel_q     <= '0;
      line_q      <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      halt_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pixel_q     <= pixel_d;
      line_q      <= line_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      halt_q      <= halt_d;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pixel_d = pixel_q;
    line_d  = line_q;
    unique case (state_q)
      STOPPED: begin
        pixel_d = '0;
        line_d  = '0;
        if (vt.run) state_d = RUNNING;
      end
      RUNNING: begin
        if (pixel_q == H_LAST) begin
          pixel_d = '0;
          if (line_q == V_LAST) begin
            // run is only honoured here, so a frame is never cut short
            line_d = '0;
            if (!vt.run) state_d = STOPPED;
          end else begin
            line_d = line_q + 12'd1;
          end
        end else begin
          pixel_d = pixel_q + 12'd1;
        end
      end
      default: state_d = STOPPED;
    endcase

    // Strobes are registered from the next coordinates so they align with them
    line_end_d  = (state_d == RUNNING) && (pixel_d == H_LAST);
    frame_end_d = line_end_d && (line_d == V_LAST);
    halt_d      = (state_d == STOPPED);
  end

  always_comb begin
    sync_raw = '0;
    if (state_q == RUNNING) begin
      sync_raw.hs = (pixel_q >= HS_FIRST) && (pixel_q <= HS_LAST);
      sync_raw.vs = (line_q >= VS_FIRST) && (line_q <= VS_LAST);
      sync_raw.de = (pixel_q <= H_ACT_LAST) && (line_q <= V_ACT_LAST);
    end
  end

  // The delay line carries "active" flags; polarity is applied at the pins
  // so a cleared pipeline always means inactive levels.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign sync_out = sync_raw;
  end else begin : g_delay
    sync_t pipe_q [SYNC_DELAY];
    sync_t pipe_d [SYNC_DELAY];

    always_comb begin
      pipe_d[0] = sync_raw;
      for (int i = 1; i < SYNC_DELAY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_DELAY; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign sync_out = pipe_q[SYNC_DELAY-1];
  end

  assign vt.pixel     = pixel_q;
  assign vt.line      = line_q;
  assign vt.line_end  = line_end_q;
  assign vt.frame_end = frame_end_q;
  assign vt.halt      = halt_q;
  assign vt.hsync     = HS_POL ? sync_out.hs : ~sync_out.hs;
  assign vt.vsync     = VS_POL ? sync_out.vs : ~sync_out.vs;
  assign vt.de        = sync_out.de;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing with a 14x7 raster and a 2-clock sync delay.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;

  video_timing_if vt ();

  video_timing #(
    .H_ACTIVE  (8),
    .H_FP      (2),
    .H_SYNC    (2),
    .H_BP      (2),
    .V_ACTIVE  (4),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1),
    .HS_POL    (1'b1),
    .VS_POL    (1'b1),
    .SYNC_DELAY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vt (vt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] pixel;
    logic [11:0] line;
    logic        line_end;
    logic        frame_end;
    logic        halt;
    logic        hsync;
    logic        vsync;
    logic        de;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event sample_ev;

  // Running totals of DUT activity, owned by the monitor
  int cnt_le = 0, cnt_fe = 0, cnt_hs = 0, cnt_vs = 0, cnt_de = 0;

  // Reference raster: m_t counts clocks since RUNNING began
  bit       m_running = 1'b0;
  int       m_t       = 0;
  bit [2:0] d1        = '0;
  bit [2:0] d2        = '0;

  function automatic int m_pix();
    return m_running ? (m_t % 14) : 0;
  endfunction

  function automatic int m_line();
    return m_running ? ((m_t / 14) % 7) : 0;
  endfunction

  function automatic obs_t observe();
    return {vt.pixel, vt.line, vt.line_end, vt.frame_end, vt.halt,
            vt.hsync, vt.vsync, vt.de};
  endfunction

  task automatic check_obs(input string tag, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got pix=%0d line=%0d le=%b fe=%b halt=%b hs=%b vs=%b de=%b, expected pix=%0d line=%0d le=%b fe=%b halt=%b hs=%b vs=%b de=%b",
               tag, $time, got.pixel, got.line, got.line_end, got.frame_end,
               got.halt, got.hsync, got.vsync, got.de,
               want.pixel, want.line, want.line_end, want.frame_end,
               want.halt, want.hsync, want.vsync, want.de);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Expected view for the current model state; sync outputs lag raw by 2
  task automatic push_expected(input string tag);
    int       p;
    int       l;
    bit [2:0] raw;
    obs_t     e;
    exp_t     x;
    p   = m_pix();
    l   = m_line();
    raw = m_running ? {(p >= 10 && p <= 11), (l == 5), (p < 8 && l < 4)} : 3'b000;
    e.pixel     = 12'(p);
    e.line      = 12'(l);
    e.line_end  = m_running && (p == 13);
    e.frame_end = m_running && (p == 13) && (l == 6);
    e.halt      = !m_running;
    e.hsync     = d2[2];
    e.vsync     = d2[1];
    e.de        = d2[0];
    x.tag = tag;
    x.v   = e;
    exp_q.push_back(x);
    d2 = d1;
    d1 = raw;
  endtask

  task automatic step(input bit r, input string tag);
    vt.run = r;
    if (!m_running) begin
      if (r) begin
        m_running = 1'b1;
        m_t       = 0;
      end
    end else if ((m_t % 98) == 97 && !r) begin
      m_running = 1'b0;
    end else begin
      m_t++;
    end
    @(posedge clk);
    #1;
    push_expected(tag);
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_t       = 0;
    d1        = '0;
    d2        = '0;
  endtask

  // Monitor: compares on every falling edge, or immediately on sample_ev
  initial begin
    obs_t o;
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      o = observe();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_obs(e.tag, o, e.v);
      end
      if (!rst && !clk) begin
        cnt_le += int'(o.line_end);
        cnt_fe += int'(o.frame_end);
        cnt_hs += int'(o.hsync);
        cnt_vs += int'(o.vsync);
        cnt_de += int'(o.de);
      end
    end
  end

  initial begin
    int s_le, s_fe, s_hs, s_vs, s_de;
    vt.run = 1'b0;
    model_reset();

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 push_expected("reset_async");
    -> sample_ev;
    @(posedge clk);
    #1 push_expected("reset_hold");
    #1 rst = 1'b0;

    repeat (3) step(1'b0, "stopped_idle");
    step(1'b1, "first_running");
    repeat (100) step(1'b1, "run");

    // One full frame window in steady state
    s_le = cnt_le; s_fe = cnt_fe; s_hs = cnt_hs; s_vs = cnt_vs; s_de = cnt_de;
    repeat (98) step(1'b1, "run_window");
    check_int("line_end_per_frame", cnt_le - s_le, 7);
    check_int("frame_end_per_frame", cnt_fe - s_fe, 1);
    check_int("hsync_per_frame", cnt_hs - s_hs, 14);
    check_int("vsync_per_frame", cnt_vs - s_vs, 14);
    check_int("de_per_frame", cnt_de - s_de, 32);

    // Drop run mid-frame at pixel 3, line 2: the frame must complete
    for (int i = 0; i < 200 && !(m_pix() == 3 && m_line() == 2); i++) step(1'b1, "run");
    for (int i = 0; i < 200 && m_running; i++) step(1'b0, "drain_frame");
    repeat (4) step(1'b0, "stopped_after_drop");

    // Restart from STOPPED and run straight through a frame_end
    step(1'b1, "restart");
    repeat (110) step(1'b1, "wrap_no_stop");

    // Asynchronous reset mid-line at pixel 5, line 1, between clock edges
    for (int i = 0; i < 200 && !(m_pix() == 5 && m_line() == 1); i++) step(1'b1, "run");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    push_expected("rst_midline");
    -> sample_ev;
    @(posedge clk);
    #1 push_expected("rst_held");
    #1 rst = 1'b0;
    step(1'b1, "post_rst_start");
    repeat (20) step(1'b1, "post_rst_run");

    @(negedge clk);
    #1 check_int("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator that sits directly upstream of video_controller.
- Produces the pixel/line coordinates, the line_end/frame_end strobes and the halt qualifier that video_controller consumes.
- Produces hsync/vsync/de for the output encoder. These are delayed so they line up with video_controller's registered Y/Cb/Cr.
- Supports frame-aligned start/stop of the raster via the run input.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- SYNC_DELAY, 2, pipeline stages applied to hsync/vsync/de (0 allowed)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  raster enable, sampled only at frame boundaries
- pixel  out  12  horizontal position, 0..H_TOTAL-1
- line  out  12  vertical position, 0..V_TOTAL-1
- line_end  out  1  one-cycle strobe on the last pixel of every line
- frame_end  out  1  one-cycle strobe on the last pixel of the last line
- halt  out  1  high while the raster is stopped
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- de  out  1  delayed active-video flag

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750 by default). Both must be at most 4096.
- Reset is asynchronous, active-high, and clears everything:
  - state = STOPPED, pixel = 0, line = 0.
  - line_end = 0, frame_end = 0, halt = 1.
  - The delay line is cleared, so hsync/vsync are at their inactive levels (~HS_POL/~VS_POL) and de = 0.
- States:
  - STOPPED: counters hold at 0/0; strobes 0; halt = 1. When run = 1, go to RUNNING on the next clock. The first RUNNING cycle shows pixel = 0, line = 0 with halt = 0.
  - RUNNING: pixel increments every clock.
    - At pixel = H_TOTAL-1: pixel wraps to 0 and line increments.
    - At line = V_TOTAL-1 on that same cycle: line wraps to 0.
- run is sampled only in the cycle where frame_end = 1.
  - If run = 0 there, the next cycle enters STOPPED with pixel = 0, line = 0, halt = 1.
  - Deasserting run mid-frame never truncates the frame.
- All outputs are registered and mutually aligned:
  - line_end = 1 exactly in the cycle where pixel output = H_TOTAL-1.
  - frame_end = 1 exactly in the cycle where pixel = H_TOTAL-1 and line = V_TOTAL-1.
  - In that last cycle line_end is also 1; consumers give frame_end priority.
  - Both strobes are 0 in STOPPED.
- Undelayed sync terms, computed from the current pixel/line outputs, RUNNING only:
  - hs_raw active when H_ACTIVE+H_FP ≤ pixel < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP ≤ line < V_ACTIVE+V_FP+V_SYNC. It changes only at pixel = 0 boundaries.
  - de_raw = (pixel < H_ACTIVE) and (line < V_ACTIVE).
- hsync/vsync/de are hs_raw/vs_raw/de_raw delayed by exactly SYNC_DELAY clocks through a shift register.
  - In STOPPED the shift register input is the inactive level, so the outputs go inactive SYNC_DELAY clocks after stopping.
- A first-cycle de_raw = 1 at pixel 0/line 0 is required.
- Reset asserted mid-frame returns immediately to the reset values. After release the block waits in STOPPED for run.

Test Plan:
- Small parameters (H 8/2/2/2 → H_TOTAL = 14; V 4/1/1/1 → V_TOTAL = 7; SYNC_DELAY = 2), rst pulse then run = 1:
  - first RUNNING cycle pixel = 0, line = 0, halt = 0.
  - line_end high every 14th cycle at pixel = 13.
  - frame_end high once per 98 cycles at pixel = 13, line = 6, with line_end also high.
- Same setup, sync check:
  - hsync = HS_POL for exactly 2 cycles, beginning 2 clocks after pixel = 10.
  - vsync active while the delayed line = 5 (per-cycle check: 14 cycles).
  - de high 8 cycles per line on lines 0..3 only, shifted by 2 clocks.
- Drop run at pixel 3, line 2:
  - frame continues to frame_end.
  - Next cycle shows halt = 1, pixel = 0, line = 0, strobes 0.
  - hsync/vsync/de go inactive within 2 clocks.
- Reraise run while in STOPPED: counting resumes the following cycle from 0/0. Assert run again at frame_end: no stop occurs, and line wraps 6 → 0.
- Assert rst asynchronously mid-line (pixel = 5, line = 1), not on a clock edge:
  - outputs reach reset values before the next edge.
  - After release with run = 1, the raster restarts at 0/0.
- Default parameters, 3 frames:
  - frame_end period = 1 237 500 clocks.
  - max pixel = 1649, max line = 749.
  - de high count per frame = 921 600.
